// File: rtl/switch_sequencer.sv
// CPU A/B active-unit switchover: debounces health lines, keeps error tallies,
// picks a target CPU and swaps the host select only once the outgoing TX line is idle.
module switch_sequencer #(
  parameter int DEB_T  = 16,
  parameter int IDLE_T = 3472,
  parameter int HOLD_T = 1000000,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             io_a,
  input  logic             io_b,
  input  logic             force_swi,
  input  logic             com_swi,
  input  logic             srx_cpuA,
  input  logic             srx_cpuB,
  output logic             switch,
  output logic             busy,
  output logic             fault_both,
  output logic             force_rej,
  output logic [CNT_W-1:0] a_err_num,
  output logic [CNT_W-1:0] b_err_num,
  output logic [7:0]       swi_count,
  output logic [1:0]       state_o
);

  localparam int DW = (DEB_T  > 1) ? $clog2(DEB_T + 1)  : 1;
  localparam int IW = (IDLE_T > 1) ? $clog2(IDLE_T + 1) : 1;
  localparam int HW = (HOLD_T > 1) ? $clog2(HOLD_T + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWAP   = 2'd2
  } state_t;

  // Index 0 is CPU A, index 1 is CPU B throughout.
  logic [1:0]       io_v;
  logic [1:0]       s1_q, s2_q, err_q, err_prev_q;
  logic [DW-1:0]    deb_q [2];
  logic             force_prev_q;
  logic [CNT_W-1:0] a_q, b_q, a_d, b_d;
  logic             fault_q, rej_q;
  state_t           state_q;
  logic             switch_q, busy_q, fpend_q, ftgt_q;
  logic [7:0]       swi_q;
  logic [HW-1:0]    hold_q;
  logic [IW-1:0]    idle_q;

  logic [1:0] rise;
  logic       force_edge, tgt_err, force_acc, force_rej_d;
  logic       err_sw, srx_cur, target;

  assign io_v = {io_b, io_a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 2'b11;
      s2_q       <= 2'b11;
      err_q      <= 2'b00;
      err_prev_q <= 2'b00;
      deb_q[0]   <= '0;
      deb_q[1]   <= '0;
    end else begin
      s1_q       <= io_v;
      s2_q       <= s1_q;
      err_prev_q <= err_q;
      for (int i = 0; i < 2; i++) begin
        // A low sample disagrees with err=0 and a high sample with err=1.
        if (s2_q[i] == err_q[i]) begin
          if (deb_q[i] == DW'(DEB_T - 1)) begin
            err_q[i] <= ~err_q[i];
            deb_q[i] <= '0;
          end else begin
            deb_q[i] <= deb_q[i] + DW'(1);
          end
        end else begin
          deb_q[i] <= '0;
        end
      end
    end
  end

  assign rise        = err_q & ~err_prev_q;
  assign force_edge  = force_swi & ~force_prev_q;
  assign tgt_err     = com_swi ? err_q[1] : err_q[0];
  assign force_acc   = force_edge & ~tgt_err;
  assign force_rej_d = force_edge & tgt_err;

  always_comb begin
    a_d = a_q;
    b_d = b_q;
    if (force_acc) begin
      a_d = '0;
      b_d = '0;
    end else begin
      // Halving both keeps the A/B ordering while making room for the increment.
      if ((rise[0] && (a_q == CNT_MAX)) || (rise[1] && (b_q == CNT_MAX))) begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
      end
      a_d = a_d + CNT_W'(rise[0]);
      b_d = b_d + CNT_W'(rise[1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      force_prev_q <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      fault_q      <= 1'b0;
      rej_q        <= 1'b0;
    end else begin
      force_prev_q <= force_swi;
      a_q          <= a_d;
      b_q          <= b_d;
      fault_q      <= err_q[0] & err_q[1];
      rej_q        <= force_rej_d;
    end
  end

  assign err_sw  = switch_q ? err_q[1] : err_q[0];
  assign srx_cur = switch_q ? srx_cpuB : srx_cpuA;

  always_comb begin
    target = switch_q;
    if (err_q[0] && !err_q[1])      target = 1'b1;
    else if (err_q[1] && !err_q[0]) target = 1'b0;
    else if (err_q[0] && err_q[1])  target = switch_q;
    else if (fpend_q)               target = ftgt_q;
    else if (a_q > b_q)             target = 1'b1;
    else if (a_q < b_q)             target = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_ACTIVE;
      switch_q <= 1'b0;
      busy_q   <= 1'b0;
      swi_q    <= '0;
      hold_q   <= '0;
      idle_q   <= '0;
      fpend_q  <= 1'b0;
      ftgt_q   <= 1'b0;
    end else begin
      if (hold_q != '0) hold_q <= hold_q - HW'(1);
      case (state_q)
        ST_ACTIVE: begin
          if ((target != switch_q) && ((hold_q == '0) || fpend_q || err_sw)) begin
            state_q <= ST_DRAIN;
            busy_q  <= 1'b1;
            idle_q  <= '0;
          end
        end
        ST_DRAIN: begin
          if (target == switch_q) begin
            state_q <= ST_ACTIVE;
            busy_q  <= 1'b0;
          end else if (err_sw || (srx_cur && (idle_q == IW'(IDLE_T - 1)))) begin
            state_q <= ST_SWAP;
          end else if (srx_cur) begin
            idle_q <= idle_q + IW'(1);
          end else begin
            idle_q <= '0;
          end
        end
        ST_SWAP: begin
          switch_q <= ~switch_q;
          swi_q    <= swi_q + 8'd1;
          hold_q   <= HW'(HOLD_T - 1);
          state_q  <= ST_ACTIVE;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q <= ST_ACTIVE;
          busy_q  <= 1'b0;
        end
      endcase
      // A request for the CPU already active is accepted but needs no swap.
      if (force_acc) begin
        if (com_swi == switch_q) begin
          fpend_q <= 1'b0;
        end else begin
          fpend_q <= 1'b1;
          ftgt_q  <= com_swi;
        end
      end else if (state_q == ST_SWAP) begin
        fpend_q <= 1'b0;
      end
    end
  end

  assign switch     = switch_q;
  assign busy       = busy_q;
  assign fault_both = fault_q;
  assign force_rej  = rej_q;
  assign a_err_num  = a_q;
  assign b_err_num  = b_q;
  assign swi_count  = swi_q;
  assign state_o    = state_q;

endmodule

// File: doc/switch_sequencer.md
# switch_sequencer

Sequences the CPU A/B active-unit switchover for the dual-redundant core. It filters the two CPU health lines, keeps per-CPU error tallies and resolves health, tally and forced-command inputs into a target CPU. It drives the `switch` select only after the outgoing CPU's transmit line has been idle long enough, so a host frame is never cut mid-byte. It sits between the health/command inputs and the host-UART mux plus GPIO/LED decode.

## Interface
- `DEB_T`, default 16: consecutive stable synchronized cycles needed to change a debounced error state.
- `IDLE_T`, default 3472: consecutive high cycles on the outgoing CPU's `srx` line required before a swap.
- `HOLD_T`, default 1000000: minimum dwell in clocks after a swap before a tally-driven swap.
- `CNT_W`, default 8: error tally width.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `io_a`, `io_b` input 1: CPU health, asynchronous; low means error.
- `force_swi` input 1: forced-switch request, level; its rising edge is the request.
- `com_swi` input 1: forced target, sampled on the `force_swi` rising edge; 0 = A, 1 = B.
- `srx_cpuA`, `srx_cpuB` input 1: CPU transmit lines, monitored for idle.
- `switch` output 1: active CPU; 0 = A, 1 = B.
- `busy` output 1: high while in DRAIN or SWAP.
- `fault_both` output 1: both debounced errors are asserted.
- `force_rej` output 1: one-cycle pulse when a forced request is rejected.
- `a_err_num`, `b_err_num` output CNT_W: error tallies.
- `swi_count` output 8: completed swaps, wraps 255→0.

## Operation
- **Sync and debounce.** Each `io_x` passes through a 2-flop synchronizer, then a DEB_T filter.
  - `err_x` sets after DEB_T consecutive low samples.
  - `err_x` clears after DEB_T consecutive high samples.
- **Tallies.** A rising edge of `err_x` increments `x_err_num`.
  - If an increment would take a tally past 2^CNT_W−1, both tallies are first shifted right by 1, then the increment is applied. Ordering is preserved.
  - An accepted force clears both tallies to 0, overriding any same-cycle increment.
- **Force latch.** A `force_swi` rising edge latches `fpend=1` and `ftgt=com_swi`.
  - If `err_ftgt` is set at latch time, the request is rejected: `force_rej` pulses, `fpend` stays 0, and tallies are unchanged.
  - `fpend` clears when its SWAP completes, or when `ftgt==switch` at acceptance (no swap, tallies still cleared).
  - A new edge while `fpend=1` overwrites `ftgt`.
- **Target selection, priority order.**
  1. `err_a & ~err_b` selects B.
  2. `err_b & ~err_a` selects A.
  3. Both errors: hold the current CPU and assert `fault_both`.
  4. `fpend`: select `ftgt`.
  5. `a_err_num > b_err_num`: B. `<`: A. Equal: hold.
- **State ACTIVE.** Go to DRAIN when `target != switch` and any of these holds:
  - the hold timer is 0;
  - `fpend`;
  - `err_switch` is set (current CPU faulty).
- **State DRAIN.** `idle_cnt` counts consecutive high samples of `srx` for the current CPU (A when `switch==0`) and resets to 0 on any low sample.
  - Go to SWAP when `idle_cnt == IDLE_T−1` with `srx` high, or immediately if `err_switch` is set.
  - Return to ACTIVE without swapping if `target == switch`.
- **State SWAP** (one cycle).
  - `switch <= ~switch`.
  - `swi_count` increments.
  - Hold timer loads HOLD_T−1 and counts down to 0 in all states.
  - Clear `fpend`, then go to ACTIVE.

## Timing
- **Reset values:**
  - state ACTIVE, `switch=0`, `busy=0`, `fault_both=0`, `force_rej=0`;
  - tallies 0, `swi_count=0`, hold timer 0, `fpend=0`;
  - debounced errors 0, synchronizers preset to 1.
- **Reset mid-DRAIN or mid-SWAP:** the same reset values apply and no partial toggle occurs.
- **`io_x` to `err_x`:** 2 + DEB_T cycles.
- **`err_x` to tally update:** 1 cycle.
- **Idle swap:** `switch` toggles on the edge ending SWAP, which is 1 cycle after DRAIN's final idle sample.
- **Fault-waived swap:** `switch` toggles 3 cycles after `err_switch` rises (ACTIVE→DRAIN→SWAP→toggle).
- **`fault_both`:** registered, 1 cycle after both errors are set.
- **`busy`:** registered from the state; high in DRAIN and SWAP.
- **Simultaneous events:**
  - Tally edges on both CPUs in one cycle: both increment.
  - A force edge in the same cycle as a tally edge: the force clear wins.

## Test plan
- DEB_T=4, IDLE_T=10, HOLD_T=50. `io_a` low 3 cycles then high → no `err_a`, tallies 0. `io_a` low 10 cycles → `err_a`, `a_err_num=1`, DRAIN then SWAP, `switch=1` within 3 cycles of `err_a`, `swi_count=1`.
- Tally swap: `a_err_num=3`, `b_err_num=1`, both healthy, `srx_cpuA` toggling every 5 cycles → stays in DRAIN. Hold `srx_cpuA` high 10 cycles → `switch=1` on the next edge.
- Force: `switch=1`, `com_swi=0`, `force_swi` rises → tallies 0, swap to A after idle even though the hold timer is nonzero. With `err_a` set instead → `force_rej` pulses, `switch` stays 1.
- Both CPUs faulted → `fault_both=1`, `switch` unchanged, `busy=0`.
- Overflow at CNT_W=3: `a_err_num=7`, `b_err_num=4`, a new A error edge → `a_err_num=4`, `b_err_num=2`.
- `rst_n` asserted mid-DRAIN → all outputs return to reset values asynchronously; after release `switch=0` and `swi_count=0`.
